// File: rtl/sim_dmi_bridge.sv
// Host-to-DMI transport bridge: buffered requests, bounded outstanding count,
// response skid register, post-reset holdoff, response timeout and latched exit code.
module sim_dmi_bridge #(
  parameter int ADDR_BITS       = 7,
  parameter int DATA_BITS       = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 1,
  parameter int RESET_HOLDOFF   = 1,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_req_valid,
  output logic                 host_req_ready,
  input  logic [ADDR_BITS-1:0] host_req_addr,
  input  logic [1:0]           host_req_op,
  input  logic [DATA_BITS-1:0] host_req_data,
  output logic                 host_resp_valid,
  input  logic                 host_resp_ready,
  output logic [1:0]           host_resp_resp,
  output logic [DATA_BITS-1:0] host_resp_data,
  input  logic                 host_exit_valid,
  input  logic [31:0]          host_exit_code,
  output logic                 debug_req_valid,
  input  logic                 debug_req_ready,
  output logic [ADDR_BITS-1:0] debug_req_bits_addr,
  output logic [1:0]           debug_req_bits_op,
  output logic [DATA_BITS-1:0] debug_req_bits_data,
  input  logic                 debug_resp_valid,
  output logic                 debug_resp_ready,
  input  logic [1:0]           debug_resp_bits_resp,
  input  logic [DATA_BITS-1:0] debug_resp_bits_data,
  output logic [31:0]          exit,
  output logic                 timeout,
  output logic                 proto_err
);

  localparam int PTR_W  = $clog2(REQ_DEPTH);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int HOLD_W = $clog2(RESET_HOLDOFF + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENT_W  = ADDR_BITS + 2 + DATA_BITS;

  typedef enum logic [1:0] {ST_HOLDOFF, ST_RUN, ST_DONE} state_t;

  state_t               state_reg;
  logic [ENT_W-1:0]     fifo_mem [REQ_DEPTH];
  logic [PTR_W:0]       wr_ptr_reg, rd_ptr_reg;
  logic [OUT_W-1:0]     outstanding_reg;
  logic [HOLD_W-1:0]    holdoff_reg;
  logic [TMR_W-1:0]     timer_reg;
  logic                 skid_full_reg;
  logic [1:0]           skid_resp_reg;
  logic [DATA_BITS-1:0] skid_data_reg;
  logic [31:0]          exit_reg, exit_next;
  logic                 timeout_reg, proto_err_reg;

  logic fifo_empty, fifo_full, running, active, can_issue;
  logic req_push, req_pop, resp_fire, host_resp_fire, timer_hit, host_exit_take;
  logic [ENT_W-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign running    = !reset && (state_reg == ST_RUN);
  assign active     = !reset && (state_reg != ST_HOLDOFF);
  assign can_issue  = (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
  assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  assign host_req_ready   = running && !fifo_full;
  assign debug_req_valid  = running && !fifo_empty && can_issue;
  assign debug_resp_ready = active && (!skid_full_reg || host_resp_ready);
  assign host_resp_valid  = active && skid_full_reg;

  // Data outputs are forced to zero during reset so nothing stale leaks out.
  assign debug_req_bits_addr = reset ? '0 : fifo_head[ENT_W-1 -: ADDR_BITS];
  assign debug_req_bits_op   = reset ? '0 : fifo_head[DATA_BITS +: 2];
  assign debug_req_bits_data = reset ? '0 : fifo_head[DATA_BITS-1:0];
  assign host_resp_resp      = reset ? '0 : skid_resp_reg;
  assign host_resp_data      = reset ? '0 : skid_data_reg;
  assign exit                = reset ? '0 : exit_reg;
  assign timeout             = !reset && timeout_reg;
  assign proto_err           = !reset && proto_err_reg;

  assign req_push       = host_req_valid && host_req_ready;
  assign req_pop        = debug_req_valid && debug_req_ready;
  assign resp_fire      = debug_resp_valid && debug_resp_ready;
  assign host_resp_fire = host_resp_valid && host_resp_ready;
  assign timer_hit      = (outstanding_reg != '0) && !resp_fire &&
                          (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
  assign host_exit_take = host_exit_valid && (host_exit_code != 32'h0) &&
                          (exit_reg == 32'h0) && (state_reg != ST_DONE);

  // Host exit takes priority over a timeout firing in the same cycle.
  always_comb begin
    exit_next = exit_reg;
    if (host_exit_take)
      exit_next = host_exit_code;
    else if (timer_hit && exit_reg == 32'h0)
      exit_next = 32'h3;
  end

  always_ff @(posedge clk) begin
    if (req_push)
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {host_req_addr, host_req_op, host_req_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_HOLDOFF;
      holdoff_reg     <= HOLD_W'(RESET_HOLDOFF);
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= '0;
      timer_reg       <= '0;
      skid_full_reg   <= 1'b0;
      skid_resp_reg   <= '0;
      skid_data_reg   <= '0;
      exit_reg        <= '0;
      timeout_reg     <= 1'b0;
      proto_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_HOLDOFF: begin
          if (holdoff_reg != '0)
            holdoff_reg <= holdoff_reg - 1'b1;
          if (holdoff_reg <= HOLD_W'(1))
            state_reg <= (exit_next != 32'h0) ? ST_DONE : ST_RUN;
        end
        ST_RUN:  if (exit_next != 32'h0) state_reg <= ST_DONE;
        ST_DONE: state_reg <= ST_DONE;
        default: state_reg <= ST_HOLDOFF;
      endcase

      if (req_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (req_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

      case ({req_pop, resp_fire})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase
      if (resp_fire && outstanding_reg == '0)
        proto_err_reg <= 1'b1;

      if (resp_fire) begin
        skid_full_reg <= 1'b1;
        skid_resp_reg <= debug_resp_bits_resp;
        skid_data_reg <= debug_resp_bits_data;
      end else if (host_resp_fire) begin
        skid_full_reg <= 1'b0;
      end

      // Timer saturates so the timeout fires exactly once per stall.
      if (resp_fire || outstanding_reg == '0)
        timer_reg <= '0;
      else if (timer_reg != TMR_W'(TIMEOUT_CYCLES))
        timer_reg <= timer_reg + 1'b1;
      if (timer_hit)
        timeout_reg <= 1'b1;

      exit_reg <= exit_next;
    end
  end

endmodule
